// File: rtl/sap_sequencer_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, the state
// encoding and the control-word layout used for strobe decode.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_OUT = 4'd3;
  localparam logic [3:0] OP_HLT = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JZ  = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_NOP = 4'd8;

  localparam logic [4:0] IDLE   = 5'd0;
  localparam logic [4:0] F1     = 5'd1;
  localparam logic [4:0] F2     = 5'd2;
  localparam logic [4:0] F3     = 5'd3;
  localparam logic [4:0] DECODE = 5'd4;
  localparam logic [4:0] X1     = 5'd5;
  localparam logic [4:0] X2     = 5'd6;
  localparam logic [4:0] X3     = 5'd7;
  localparam logic [4:0] J1     = 5'd8;
  localparam logic [4:0] HALT   = 5'd9;

  // Execute flavour captured in DECODE so X1..X3 strobes stay Moore.
  typedef enum logic [1:0] {K_LDA, K_ADD, K_SUB, K_OUT} xkind_t;

  typedef struct packed {
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp, lf;
  } ctrl_t;

  localparam ctrl_t CTRL_INACTIVE = '{
    cp: 1'b0, ep: 1'b0, lm: 1'b1, ce: 1'b1, li: 1'b1, ei: 1'b1, la: 1'b1,
    ea: 1'b0, su: 1'b0, eu: 1'b0, lb: 1'b1, lo: 1'b1, lp: 1'b1, lf: 1'b0};

endpackage

// File: rtl/sap_sequencer_if.sv
// Sequencer <-> datapath bundle: opcode/flags/mode in, control strobes and
// status out. master is the sequencer side, slave the datapath side.
interface sap_sequencer_if #(
  parameter int OPW  = 4,
  parameter int CNTW = 8
);
  logic [OPW-1:0]  IRData;
  logic            zf, cf, run, step;
  logic            CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, LP, LF;
  logic            halted, illegal;
  logic [CNTW-1:0] retired;
  logic [4:0]      state_o;

  modport master (
    input  IRData, zf, cf, run, step,
    output CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, LP, LF,
    output halted, illegal, retired, state_o
  );

  modport slave (
    output IRData, zf, cf, run, step,
    input  CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, LP, LF,
    input  halted, illegal, retired, state_o
  );
endinterface

// File: rtl/sap_sequencer_step_edge.sv
// Rising-edge detector for the single-step request; the edge is valid in the
// cycle step is first seen high.
module sap_step_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_step,
  output logic o_edge
);
  logic r_step_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_step_q <= 1'b0;
    else        r_step_q <= i_step;
  end

  assign o_edge = i_step & ~r_step_q;
endmodule

// File: rtl/sap_sequencer.sv
// SAP second-generation control sequencer: fetch/decode/execute FSM with
// jumps, flag-conditional branches, sticky halt, single-step and retire count.
module sap_sequencer
  import sap_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int CNTW = 8
) (
  input  logic           clk,
  input  logic           reset,
  sap_sequencer_if.master bus
);

  logic [4:0]      r_state, w_next;
  xkind_t          r_kind, w_kind_next;
  logic [CNTW-1:0] r_retired;
  logic [OPW-1:0]  w_op;
  logic            w_step_edge, w_illegal_op, w_retire;
  ctrl_t           w_ctrl;

  sap_step_edge u_step_edge (
    .clk   (clk),
    .reset (reset),
    .i_step(bus.step),
    .o_edge(w_step_edge)
  );

  assign w_op         = bus.IRData;
  assign w_illegal_op = (w_op > OPW'(8));

  always_comb begin
    w_next      = r_state;
    w_kind_next = r_kind;
    case (r_state)
      IDLE:   if (bus.run || w_step_edge) w_next = F1;
      F1:     w_next = F2;
      F2:     w_next = F3;
      F3:     w_next = DECODE;
      DECODE: begin
        w_next = IDLE;
        if (!w_illegal_op) begin
          case (w_op[3:0])
            OP_LDA:  begin w_next = X1; w_kind_next = K_LDA; end
            OP_ADD:  begin w_next = X1; w_kind_next = K_ADD; end
            OP_SUB:  begin w_next = X1; w_kind_next = K_SUB; end
            OP_OUT:  begin w_next = X1; w_kind_next = K_OUT; end
            OP_HLT:  w_next = HALT;
            OP_JMP:  w_next = J1;
            OP_JZ:   if (bus.zf) w_next = J1;
            OP_JC:   if (bus.cf) w_next = J1;
            default: w_next = IDLE;
          endcase
        end
      end
      X1:      w_next = (r_kind == K_OUT) ? IDLE : X2;
      X2:      w_next = (r_kind == K_LDA) ? IDLE : X3;
      X3:      w_next = IDLE;
      J1:      w_next = IDLE;
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  // Only genuine instruction completions count; HALT never leaves.
  assign w_retire = (w_next == IDLE) &&
                    ((r_state == DECODE) || (r_state == X1) || (r_state == X2) ||
                     (r_state == X3) || (r_state == J1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_kind    <= K_LDA;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_kind  <= w_kind_next;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_ctrl = CTRL_INACTIVE;
    case (r_state)
      F1: begin w_ctrl.ep = 1'b1; w_ctrl.lm = 1'b0; end
      F2: w_ctrl.cp = 1'b1;
      F3: begin w_ctrl.ce = 1'b0; w_ctrl.li = 1'b0; end
      X1: begin
        if (r_kind == K_OUT) begin
          w_ctrl.ea = 1'b1;
          w_ctrl.lo = 1'b0;
        end else begin
          w_ctrl.ei = 1'b0;
          w_ctrl.lm = 1'b0;
        end
      end
      X2: begin
        w_ctrl.ce = 1'b0;
        if (r_kind == K_LDA) w_ctrl.la = 1'b0;
        else                 w_ctrl.lb = 1'b0;
      end
      X3: begin
        w_ctrl.eu = 1'b1;
        w_ctrl.la = 1'b0;
        w_ctrl.lf = 1'b1;
        w_ctrl.su = (r_kind == K_SUB);
      end
      J1: begin w_ctrl.ei = 1'b0; w_ctrl.lp = 1'b0; end
      default: ;
    endcase
  end

  assign bus.CP      = w_ctrl.cp;
  assign bus.EP      = w_ctrl.ep;
  assign bus.LM      = w_ctrl.lm;
  assign bus.CE      = w_ctrl.ce;
  assign bus.LI      = w_ctrl.li;
  assign bus.EI      = w_ctrl.ei;
  assign bus.LA      = w_ctrl.la;
  assign bus.EA      = w_ctrl.ea;
  assign bus.SU      = w_ctrl.su;
  assign bus.EU      = w_ctrl.eu;
  assign bus.LB      = w_ctrl.lb;
  assign bus.LO      = w_ctrl.lo;
  assign bus.LP      = w_ctrl.lp;
  assign bus.LF      = w_ctrl.lf;
  assign bus.halted  = (r_state == HALT);
  assign bus.illegal = (r_state == DECODE) && w_illegal_op;
  assign bus.retired = r_retired;
  assign bus.state_o = r_state;

endmodule

// File: tb/tb_sap_sequencer.sv
// Self-checking bench for sap_sequencer: per-cycle strobe words are predicted
// from an instruction timing table, retire count from a modular counter.
module tb_sap_sequencer;
  logic clk, reset;
  int   checks, errors;
  int unsigned model_ret;

  sap_sequencer_if #(.OPW(5), .CNTW(8)) bus ();
  sap_sequencer_if #(.OPW(5), .CNTW(2)) bus2 ();

  sap_sequencer #(.OPW(5), .CNTW(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
  sap_sequencer #(.OPW(5), .CNTW(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [13:0] obs;
  assign obs = {bus.CP, bus.EP, bus.LM, bus.CE, bus.LI, bus.EI, bus.LA,
                bus.EA, bus.SU, bus.EU, bus.LB, bus.LO, bus.LP, bus.LF};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word expected in cycle k of an instruction (k=1 is F1); k outside
  // the instruction gives the all-inactive word.
  function automatic logic [13:0] exp_ctrl(input int op, input int k);
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp, lf;
    cp = 0; ep = 0; lm = 1; ce = 1; li = 1; ei = 1; la = 1;
    ea = 0; su = 0; eu = 0; lb = 1; lo = 1; lp = 1; lf = 0;
    case (k)
      1: begin ep = 1; lm = 0; end
      2: cp = 1;
      3: begin ce = 0; li = 0; end
      5: begin
        if (op <= 2)                begin ei = 0; lm = 0; end
        else if (op == 3)           begin ea = 1; lo = 0; end
        else if (op >= 5 && op <= 7) begin ei = 0; lp = 0; end
      end
      6: begin
        if (op == 0)                 begin ce = 0; la = 0; end
        else if (op == 1 || op == 2) begin ce = 0; lb = 0; end
      end
      7: if (op == 1 || op == 2) begin eu = 1; la = 0; lf = 1; su = (op == 2); end
      default: ;
    endcase
    return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp, lf};
  endfunction

  function automatic int instr_len(input int op, input bit taken);
    case (op)
      0:       return 6;
      1, 2:    return 7;
      3, 5:    return 5;
      6, 7:    return taken ? 5 : 4;
      default: return 4;
    endcase
  endfunction

  // Called at the negedge of an IDLE cycle; returns at the next IDLE negedge.
  // fv<0 randomizes flags in DECODE, otherwise forces both to fv.
  task automatic run_instr(input int op, input int fv);
    int len; bit taken, fz, fc;
    bus.run = 1'b1;
    checks++;
    if (bus.state_o !== 5'd0 || obs !== exp_ctrl(op, 0) || bus.retired !== 8'(model_ret)) begin
      errors++;
      $display("FAIL idle op=%0d state=%0d ctrl=%b retired=%0d exp_retired=%0d",
               op, bus.state_o, obs, bus.retired, 8'(model_ret));
    end
    bus.IRData = 5'(op);
    taken = 0;
    len = instr_len(op, 0);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_ctrl(op, k)) begin
        errors++;
        $display("FAIL ctrl op=%0d k=%0d got=%b exp=%b", op, k, obs, exp_ctrl(op, k));
      end
      checks++;
      if (bus.illegal !== (k == 4 && op > 8)) begin
        errors++;
        $display("FAIL illegal op=%0d k=%0d got=%b", op, k, bus.illegal);
      end
      fz = 1'($urandom); fc = 1'($urandom);
      if (k == 4 && fv >= 0) begin fz = fv[0]; fc = fv[0]; end
      bus.zf = fz; bus.cf = fc;
      if (k == 4) begin
        taken = (op == 6) ? fz : (op == 7) ? fc : 1'b0;
        len = instr_len(op, taken);
      end
    end
    @(negedge clk);
    model_ret = (model_ret + 1) % 256;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.run = 1'b0; bus.step = 1'b0; bus.IRData = '0;
    bus.zf = 1'b0; bus.cf = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== exp_ctrl(0, 0)) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", obs, exp_ctrl(0, 0)); end
    checks++;
    if (bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL reset_flags halted=%b illegal=%b exp 0 0", bus.halted, bus.illegal);
    end
    checks++;
    if (bus.retired !== 8'd0 || bus.state_o !== 5'd0) begin
      errors++; $display("FAIL reset_state retired=%0d state=%0d exp 0 0", bus.retired, bus.state_o);
    end
    reset = 1'b1;
    model_ret = 0;
  endtask

  task automatic test_lda();
    repeat (2) run_instr(0, -1);
  endtask

  task automatic test_sub();
    repeat (3) run_instr(2, -1);
    run_instr(1, -1);
    run_instr(3, -1);
  endtask

  task automatic test_jumps();
    run_instr(6, 1);
    run_instr(6, 0);
    run_instr(7, 1);
    run_instr(7, 0);
    run_instr(5, 0);
  endtask

  task automatic test_illegal();
    run_instr(11, -1);
    run_instr(20, -1);
    run_instr(8, -1);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 31));
      if (op == 4) op = 8;
      run_instr(op, -1);
    end
  endtask

  task automatic test_run_change();
    bus.run = 1'b1; bus.IRData = 5'd0;
    repeat (5) @(negedge clk);
    bus.run = 1'b0;
    repeat (6) @(negedge clk);
    model_ret = (model_ret + 1) % 256;
    checks++;
    if (bus.state_o !== 5'd0 || bus.retired !== 8'(model_ret)) begin
      errors++;
      $display("FAIL run_change state=%0d retired=%0d exp 0 %0d", bus.state_o, bus.retired, 8'(model_ret));
    end
  endtask

  task automatic test_step();
    bus.run = 1'b0; bus.IRData = 5'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.state_o !== 5'd0 || bus.retired !== 8'(model_ret)) begin
      errors++; $display("FAIL step_hold state=%0d retired=%0d exp 0 %0d", bus.state_o, bus.retired, 8'(model_ret));
    end
    bus.step = 1'b1; @(negedge clk); bus.step = 1'b0;
    @(negedge clk);
    bus.step = 1'b1; @(negedge clk); bus.step = 1'b0;
    repeat (8) @(negedge clk);
    model_ret = (model_ret + 1) % 256;
    checks++;
    if (bus.state_o !== 5'd0 || bus.retired !== 8'(model_ret)) begin
      errors++; $display("FAIL step_drop state=%0d retired=%0d exp 0 %0d", bus.state_o, bus.retired, 8'(model_ret));
    end
    bus.step = 1'b1; @(negedge clk); bus.step = 1'b0;
    repeat (10) @(negedge clk);
    model_ret = (model_ret + 1) % 256;
    checks++;
    if (bus.state_o !== 5'd0 || bus.retired !== 8'(model_ret)) begin
      errors++; $display("FAIL step_two state=%0d retired=%0d exp 0 %0d", bus.state_o, bus.retired, 8'(model_ret));
    end
  endtask

  task automatic test_async_reset();
    bus.run = 1'b1; bus.IRData = 5'd1;
    repeat (6) @(negedge clk);
    checks++;
    if (obs !== exp_ctrl(1, 6)) begin errors++; $display("FAIL x2_ctrl got=%b exp=%b", obs, exp_ctrl(1, 6)); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== exp_ctrl(0, 0) || bus.state_o !== 5'd0 || bus.retired !== 8'd0) begin
      errors++;
      $display("FAIL async_reset ctrl=%b state=%0d retired=%0d exp %b 0 0", obs, bus.state_o, bus.retired, exp_ctrl(0, 0));
    end
    @(negedge clk);
    reset = 1'b1;
    model_ret = 0;
  endtask

  task automatic test_halt();
    bus.run = 1'b1; bus.IRData = 5'd4;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_ctrl(4, k) || bus.halted !== 1'b0) begin
        errors++; $display("FAIL hlt_fetch k=%0d ctrl=%b halted=%b exp %b 0", k, obs, bus.halted, exp_ctrl(4, k));
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_ctrl(0, 0) || bus.halted !== 1'b1 || bus.retired !== 8'(model_ret)) begin
        errors++;
        $display("FAIL halted c=%0d ctrl=%b halted=%b retired=%0d exp %b 1 %0d",
                 c, obs, bus.halted, bus.retired, exp_ctrl(0, 0), 8'(model_ret));
      end
      bus.step = (c % 2 == 1);
    end
    reset = 1'b0; bus.step = 1'b0;
    #1;
    checks++;
    if (bus.halted !== 1'b0 || bus.retired !== 8'd0 || bus.state_o !== 5'd0) begin
      errors++; $display("FAIL halt_clear halted=%b retired=%0d state=%0d exp 0 0 0", bus.halted, bus.retired, bus.state_o);
    end
    @(negedge clk);
    reset = 1'b1;
    model_ret = 0;
  endtask

  task automatic test_wrap();
    bus.run = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (bus2.retired !== 2'(4 % 4)) begin errors++; $display("FAIL wrap4 got=%0d exp=%0d", bus2.retired, 4 % 4); end
    repeat (5) @(negedge clk);
    checks++;
    if (bus2.retired !== 2'(5 % 4) || bus2.state_o !== 5'd0) begin
      errors++; $display("FAIL wrap5 got=%0d state=%0d exp=%0d 0", bus2.retired, bus2.state_o, 5 % 4);
    end
  endtask

  initial begin
    checks = 0; errors = 0; model_ret = 0;
    bus2.IRData = 5'd8; bus2.run = 1'b1; bus2.step = 1'b0; bus2.zf = 1'b0; bus2.cf = 1'b0;
    test_reset();
    test_lda();
    test_sub();
    test_jumps();
    test_illegal();
    test_random();
    test_run_change();
    test_step();
    test_async_reset();
    test_halt();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/sap_sequencer.md
Name: sap_sequencer

Overview:
Parametrised second-generation control sequencer for the SAP datapath (PC, MAR, RAM, IR, A, B, ALU, OUT).
- Issues the same per-state control strobes as the first-generation controller.
- Adds jump and conditional-jump instructions, ALU flag capture, NOP and illegal-opcode handling, a sticky halt, single-step mode and a retired-instruction counter.
- Sits between the IR opcode field and every datapath load/enable pin.

Parameters:
OPW, 4, opcode width in bits (≥4); any opcode with nonzero bits above bit 3 is illegal.
CNTW, 8, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  asynchronous, active-low reset.
IRData  in  OPW  opcode field of IR; valid from the DECODE state onward.
zf  in  1  ALU zero flag (registered in datapath).
cf  in  1  ALU carry flag (registered in datapath).
run  in  1  1 = free-run; 0 = single-step.
step  in  1  synchronous step request; one rising edge (0→1 between samples) releases one instruction.
CP  out  1  PC increment, active-high.
EP  out  1  PC to bus, active-high.
LM  out  1  MAR load, active-low.
CE  out  1  RAM to bus, active-low.
LI  out  1  IR load, active-low.
EI  out  1  IR operand to bus, active-low.
LA  out  1  A load, active-low.
EA  out  1  A to bus, active-high.
SU  out  1  ALU subtract select, active-high.
EU  out  1  ALU to bus, active-high.
LB  out  1  B load, active-low.
LO  out  1  OUT load, active-low.
LP  out  1  PC load from bus, active-low.
LF  out  1  flag register load, active-high.
halted  out  1  sticky halt indicator.
illegal  out  1  one-cycle pulse in DECODE when the opcode is illegal.
retired  out  CNTW  retired-instruction count.
state_o  out  5  current state code (debug).

Behaviour:
- Outputs are Moore, decoded from the state register only, except `illegal`, which is decoded from state plus IRData.
- Reset (async, reset=0):
  - state=IDLE; halted=0; retired=0; step edge register=0.
  - All strobes inactive: CP=EP=EA=SU=EU=LF=0; LM=CE=LI=EI=LA=LB=LO=LP=1.
  - Reset mid-instruction aborts immediately; there is no partial completion.
- IDLE: all inactive. Next state is F1 if run=1 or a step edge is detected this cycle; otherwise stay in IDLE.
- Fetch sequence:
  - F1: EP=1, LM=0.
  - F2: CP=1.
  - F3: CE=0, LI=0.
  - DECODE: all inactive; dispatch on IRData.
- Opcodes and execute states:
  - 0 LDA: X1 EI=0,LM=0 → X2 CE=0,LA=0. 6 cycles total.
  - 1 ADD: X1 EI=0,LM=0 → X2 CE=0,LB=0 → X3 EU=1,LA=0,LF=1. 7 cycles total.
  - 2 SUB: same as ADD; in X3 additionally SU=1. 7 cycles total.
  - 3 OUT: X1 EA=1,LO=0. 5 cycles total.
  - 4 HLT: DECODE → HALT. halted=1, all strobes inactive, held until reset. run and step are ignored.
  - 5 JMP: J1 EI=0,LP=0. 5 cycles total.
  - 6 JZ: if zf sampled in DECODE =1 → J1; else → IDLE. 4 cycles when not taken.
  - 7 JC: same as JZ using cf.
  - 8 NOP: → IDLE.
  - 9–15 and any upper-bit opcode: illegal=1 for the DECODE cycle, then treated as NOP.
- Retirement:
  - After the last execute state (or DECODE for NOP, illegal and not-taken jumps), the next state is IDLE.
  - retired increments on the transition into IDLE from an instruction and wraps modulo 2^CNTW.
  - HLT does not increment.
- Free-run: IDLE lasts one cycle per instruction.
- Step mode:
  - One instruction per step edge.
  - Edges arriving outside IDLE are dropped, not queued.
  - run changing mid-instruction takes effect at the next IDLE.
- Flags are sampled only in DECODE; changes at other times have no effect.

Decomposition:
- Shared package sap_pkg holds:
  - opcode constants OP_LDA..OP_NOP;
  - state encoding localparams IDLE, F1, F2, F3, DECODE, X1, X2, X3, J1, HALT (5-bit);
  - inactive control-word constant.
- One sub-module, sap_step_edge: a registered 0→1 detector on step, with async active-low reset.

Test Plan:
- Reset released, run=1, IRData=0 (LDA): strobes follow F1,F2,F3,DECODE,X1,X2 over 6 cycles; CE=LA=0 in cycle 6; retired goes 0→1 on the 7th edge.
- IRData=2 (SUB): X3 shows EU=1, SU=1, LA=0, LF=1; 7 cycles per instruction; retired increments by 1 each instruction.
- IRData=6 with zf=1: J1 has EI=0, LP=0. With zf=0: IDLE follows DECODE with LP never asserted; both cases retire.
- IRData=4: halted=1 from the cycle after DECODE; strobes stay inactive for 20 cycles despite run=1 and step pulses; reset=0 clears halted and retired.
- run=0, three step pulses (one during F2): exactly two instructions execute; state_o returns to IDLE; retired=2.
- IRData=4'hB: illegal=1 for one cycle, no strobes asserted, retired increments. With CNTW=2, five NOPs give retired=1 (wrap). Asserting reset during X2 of ADD forces IDLE and reset output values asynchronously.
